// File: rtl/psram_arbiter.sv
// Round-robin two-port arbiter in front of the QPI PSRAM driver (A: write-only stream, B: host rd/wr).
// Define PSRAM_ARB_TIMEOUT_EN to abort transactions that never see mem_done.
module psram_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              a_err,
    output logic              b_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_b;
    logic              r_own_b;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_a_ack;
    logic              r_b_ack;
    logic [3:0]        r_gap;

    logic w_grant_b;
    logic w_start;
    logic w_timeout;
    logic w_finish;

    // B wins when it is alone or when A was the last port served.
    assign w_grant_b = b_req && (!a_req || !r_last_b);
    assign w_start   = (r_state == S_IDLE) && mem_ready && (a_req || b_req);
    assign w_finish  = (r_state == S_ISSUE) && (mem_done || w_timeout);

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_a_err;
    logic          r_b_err;

    // A real mem_done in the final cycle still wins over the abort.
    assign w_timeout = (r_state == S_ISSUE) && !mem_done && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_ISSUE) ? r_to_cnt + 1'b1 : '0;
            r_a_err  <= w_finish && !r_own_b && w_timeout;
            r_b_err  <= w_finish &&  r_own_b && w_timeout;
        end
    end

    assign a_err = r_a_err;
    assign b_err = r_b_err;
`else
    assign w_timeout = 1'b0;
    assign a_err     = 1'b0;
    assign b_err     = 1'b0;
`endif

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last_b <= 1'b1;
            r_own_b  <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_gap    <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_own_b  <= w_grant_b;
                        r_last_b <= w_grant_b;
                        r_state  <= S_ISSUE;
                        if (w_grant_b) begin
                            r_addr  <= b_addr;
                            r_wdata <= b_wdata;
                            r_rd    <= !b_we;
                            r_wr    <= b_we;
                        end else begin
                            r_addr  <= a_addr;
                            r_wdata <= a_wdata;
                            r_rd    <= 1'b0;
                            r_wr    <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_finish) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_a_ack <= !r_own_b;
                        r_b_ack <= r_own_b;
                        if (r_own_b && r_rd)
                            r_rdata <= w_timeout ? DATA_W'(16'hDEAD) : mem_rdata;
                        r_gap   <= 4'(GAP_CYC - 1);
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == 4'd0) r_state <= S_IDLE;
                    else               r_gap   <= r_gap - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd    = r_rd;
    assign mem_wr    = r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;
    assign b_rdata   = r_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: transaction vector table plus hand-written corner sequences.
module tb_psram_arbiter;

    logic        mem_clk = 1'b0;
    logic        rst_n;
    logic        mem_ready, mem_done;
    logic [15:0] mem_rdata;
    logic        mem_rd, mem_wr;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        a_req, a_ack, b_req, b_we, b_ack, a_err, b_err, busy;
    logic [23:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata, b_rdata;

    int n_vec = 0;
    int n_err = 0;

    psram_arbiter dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .mem_ready(mem_ready), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err), .busy(busy)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        bit          a_req, b_req, b_we;
        logic [23:0] a_addr, b_addr;
        logic [15:0] a_wdata, b_wdata, rdata;
        int          dly;
        bit          exp_b, exp_rd;
        logic [23:0] exp_addr;
        logic [15:0] exp_wdata, exp_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    // Ticks until a strobe is seen (bounded); n returns the number of edges waited.
    task automatic wait_strobe(input string name, output int n);
        n = 0;
        while (!(mem_rd || mem_wr) && n < 40) begin
            tick();
            n++;
        end
        chk({name, " strobe seen"}, 32'(mem_rd | mem_wr), 32'd1);
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int    n, hi;
        string s;
        s = $sformatf("vec%0d", idx);
        a_req = v.a_req; b_req = v.b_req; b_we = v.b_we;
        a_addr = v.a_addr; b_addr = v.b_addr; a_wdata = v.a_wdata; b_wdata = v.b_wdata;
        wait_strobe(s, n);
        chk({s, " mem_rd"}, 32'(mem_rd), 32'(v.exp_rd));
        chk({s, " mem_wr"}, 32'(mem_wr), 32'(!v.exp_rd));
        chk({s, " mem_addr"}, 32'(mem_addr), 32'(v.exp_addr));
        chk({s, " mem_wdata"}, 32'(mem_wdata), 32'(v.exp_wdata));
        hi = 1;
        for (int k = 1; k < v.dly; k++) begin
            tick();
            if (mem_rd == v.exp_rd && mem_wr == !v.exp_rd && mem_addr == v.exp_addr) hi++;
        end
        chk({s, " strobe held cycles"}, 32'(hi), 32'(v.dly));
        mem_rdata = v.rdata; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk({s, " strobe cleared"}, 32'({mem_rd, mem_wr}), 32'd0);
        chk({s, " a_ack"}, 32'(a_ack), 32'(!v.exp_b));
        chk({s, " b_ack"}, 32'(b_ack), 32'(v.exp_b));
        chk({s, " b_rdata"}, 32'(b_rdata), 32'(v.exp_rdata));
        chk({s, " err"}, 32'(a_err | b_err), 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        tick();
        chk({s, " ack one cycle"}, 32'(a_ack | b_ack), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000100, 16'h0000, 16'h0000, 16'hABCD, 18, 1'b1, 1'b1, 24'h000100, 16'h0000, 16'hABCD};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 24'h000200, 24'h000300, 16'h1111, 16'h2222, 16'h5555,  5, 1'b0, 1'b0, 24'h000200, 16'h1111, 16'hABCD};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 24'h000200, 24'h000300, 16'h1111, 16'h2222, 16'h6666,  4, 1'b1, 1'b0, 24'h000300, 16'h2222, 16'hABCD};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'h000000, 16'hFFFF, 16'h0000, 16'h7777,  1, 1'b0, 1'b0, 24'hFFFFFF, 16'hFFFF, 16'hABCD};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 24'h000001, 24'h000000, 16'h8001, 16'h0000, 16'h1234,  2, 1'b0, 1'b0, 24'h000001, 16'h8001, 16'hABCD};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 24'h000002, 24'h123456, 16'h9999, 16'h4321, 16'h0BEE,  3, 1'b1, 1'b1, 24'h123456, 16'h4321, 16'h0BEE};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'hABCDEF, 16'h0000, 16'h0000, 16'hFFFF,  2, 1'b1, 1'b1, 24'hABCDEF, 16'h0000, 16'hFFFF};

        rst_n = 1'b0; mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        #12;
        chk("reset strobes", 32'({mem_rd, mem_wr}), 32'd0);
        chk("reset acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset b_rdata", 32'(b_rdata), 32'd0);
        rst_n = 1'b1;

        // No grant while the PSRAM is not ready.
        a_req = 1'b1; a_addr = 24'h000ABC; a_wdata = 16'h5A5A;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("not ready idle", 32'({mem_rd, mem_wr, busy}), 32'd0);
        end
        mem_ready = 1'b1;
        tick();
        chk("ready grant mem_wr", 32'(mem_wr), 32'd1);
        chk("ready grant mem_rd", 32'(mem_rd), 32'd0);
        chk("ready grant mem_addr", 32'(mem_addr), 32'h000ABC);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("ready a_ack", 32'(a_ack), 32'd1);
        a_req = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_txn(i, tbl[i]);

        // Continuous requests from both ports after reset: A,B,A,B with a fixed gap.
        rst_n = 1'b0; #4; rst_n = 1'b1;
        tick();
        a_addr = 24'h000A00; b_addr = 24'h000B00; b_we = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_strobe("alt", n);
            if (t > 0) chk("alt gap edges", 32'(n), 32'd3);
            chk("alt owner addr", 32'(mem_addr), (t % 2 == 1) ? 32'h000B00 : 32'h000A00);
            for (int k = 0; k < 9; k++) tick();
            mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
            chk("alt a_ack", 32'(a_ack), 32'(t % 2 == 0));
            chk("alt b_ack", 32'(b_ack), 32'(t % 2 == 1));
        end
        a_req = 1'b0; b_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("alt back to idle", 32'(busy), 32'd0);

        // Requester drops req mid-transaction; spurious mem_done in GAP is ignored.
        b_req = 1'b1; b_we = 1'b1; b_addr = 24'h000C00; b_wdata = 16'hCAFE;
        wait_strobe("drop", n);
        for (int k = 0; k < 3; k++) tick();
        b_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("drop strobe held", 32'(mem_wr), 32'd1);
        mem_done = 1'b1;
        tick();
        chk("drop b_ack", 32'(b_ack), 32'd1);
        tick();
        mem_done = 1'b0;
        chk("gap done ignored", 32'({a_ack, b_ack}), 32'd0);
        for (int k = 0; k < 10; k++) tick();
        chk("drop no regrant", 32'({mem_rd, mem_wr, busy}), 32'd0);

        // Reset during ISSUE kills the strobe asynchronously and produces no ack.
        a_req = 1'b1; a_addr = 24'h000D00; a_wdata = 16'h0D0D;
        wait_strobe("rst", n);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async reset mem_wr", 32'(mem_wr), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        a_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("killed txn no ack", 32'({a_ack, b_ack}), 32'd0);
        end
        a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 24'h000E00;
        wait_strobe("post reset tie", n);
        chk("post reset A wins", 32'(mem_addr), 32'h000D00);
        chk("post reset mem_wr", 32'(mem_wr), 32'd1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("post reset a_ack", 32'(a_ack), 32'd1);
        a_req = 1'b0; b_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();

`ifdef PSRAM_ARB_TIMEOUT_EN
        begin
            int c;
            b_req = 1'b1; b_we = 1'b0; b_addr = 24'h000F00;
            wait_strobe("timeout", n);
            c = 0;
            while (mem_rd && c < 200) begin
                c++;
                tick();
            end
            chk("timeout strobe cycles", 32'(c), 32'd64);
            chk("timeout b_ack", 32'(b_ack), 32'd1);
            chk("timeout b_err", 32'(b_err), 32'd1);
            chk("timeout b_rdata", 32'(b_rdata), 32'hDEAD);
            chk("timeout in gap", 32'(busy), 32'd1);
            b_req = 1'b0;
            tick();
            chk("timeout err pulse", 32'({b_ack, b_err}), 32'd0);
            chk("timeout still gap", 32'(busy), 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
